// File: rtl/latch_bank_write_arbiter.sv
// latch_bank_write_arbiter
//   Round-robin arbiter and enable sequencer for the single write port of a
//   master/slave D-latch register bank. One request is granted at a time.
//   For each write the bank sees: master_en pulse, an optional dead cycle,
//   a slave_en pulse, and then a one-hot ack to the winning requester.
//   Every output is driven directly from a flop.
//
//   Build option: define NONOVERLAP_GAP_EN to insert the dead (GAP) cycle
//   between master_en and slave_en, which gives 5 cycles per write. Without
//   it, MASTER goes straight to SLAVE and a write takes 4 cycles. In both
//   builds the two enables are never high in the same cycle.
module latch_bank_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [AW-1:0]        lat_addr,
  output logic [DW-1:0]        lat_d,
  output logic                 master_en,
  output logic                 slave_en,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MASTER,
    S_GAP,
    S_SLAVE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [AW-1:0]     lat_addr_q, lat_addr_d;
  logic [DW-1:0]     lat_d_q, lat_d_d;
  logic              master_en_q, master_en_d;
  logic              slave_en_q, slave_en_d;
  logic              busy_q, busy_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     scan_idx;
  int unsigned       scan;

  // Round-robin search: first set request at or after ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= NREQ) begin
        scan = scan - NREQ;
      end
      scan_idx = PW'(scan);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // State and every registered output; reset aborts any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      lat_addr_q  <= '0;
      lat_d_q     <= '0;
      master_en_q <= 1'b0;
      slave_en_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      lat_addr_q  <= lat_addr_d;
      lat_d_q     <= lat_d_d;
      master_en_q <= master_en_d;
      slave_en_q  <= slave_en_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state sequencing of one write: MASTER -> (GAP) -> SLAVE -> DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_MASTER;
        end
      end
`ifdef NONOVERLAP_GAP_EN
      S_MASTER: state_d = S_GAP;
`else
      S_MASTER: state_d = S_SLAVE;
`endif
      S_GAP:    state_d = S_SLAVE;
      S_SLAVE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so enables/ack/busy land in flops;
  // grant capture of pointer, address and data happens only leaving IDLE.
  always_comb begin
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    lat_addr_d  = lat_addr_q;
    lat_d_d     = lat_d_q;
    if (state_q == S_IDLE && win_found) begin
      grant_d    = win_idx;
      ptr_d      = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
      lat_addr_d = req_addr[int'(win_idx)*AW +: AW];
      lat_d_d    = req_data[int'(win_idx)*DW +: DW];
    end
    master_en_d = (state_d == S_MASTER);
    slave_en_d  = (state_d == S_SLAVE);
    busy_d      = (state_d != S_IDLE);
    ack_d       = '0;
    if (state_d == S_DONE) begin
      ack_d[grant_q] = 1'b1;
    end
  end

  assign ack       = ack_q;
  assign lat_addr  = lat_addr_q;
  assign lat_d     = lat_d_q;
  assign master_en = master_en_q;
  assign slave_en  = slave_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Directed testbench for latch_bank_write_arbiter (NREQ=4, DW=8, AW=3).
// Follows NONOVERLAP_GAP_EN to expect either the 5- or 4-cycle write.
module tb_latch_bank_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;

`ifdef NONOVERLAP_GAP_EN
  localparam bit HAS_GAP = 1'b1;
`else
  localparam bit HAS_GAP = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     ack;
  logic [AW-1:0]       lat_addr;
  logic [DW-1:0]       lat_d;
  logic                master_en;
  logic                slave_en;
  logic                busy;

  int unsigned n_checks;
  int unsigned n_fail;
  logic        prev_busy;
  logic [DW-1:0] prev_lat_d;

  latch_bank_write_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ack       (ack),
    .lat_addr  (lat_addr),
    .lat_d     (lat_d),
    .master_en (master_en),
    .slave_en  (slave_en),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample 1ns after the edge, check per-cycle invariants.
  task automatic cyc();
    @(posedge clk);
    #1;
    check("no_overlap", 32'(master_en & slave_en), 32'd0);
    check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    if (busy && prev_busy) begin
      check("lat_d_stable", 32'(lat_d), 32'(prev_lat_d));
    end
    prev_busy  = busy;
    prev_lat_d = lat_d;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req[i]               = 1'b1;
  endtask

  // Called while the DUT is in IDLE; the next edge must grant requester w.
  // Requester data is scrambled right after capture to prove it is not re-sampled.
  task automatic expect_write(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NREQ-1:0] exp_ack;
    exp_ack    = '0;
    exp_ack[w] = 1'b1;
    cyc();
    check("m_master_en", 32'(master_en), 32'd1);
    check("m_slave_en", 32'(slave_en), 32'd0);
    check("m_lat_addr", 32'(lat_addr), 32'(a));
    check("m_lat_d", 32'(lat_d), 32'(d));
    check("m_busy", 32'(busy), 32'd1);
    check("m_ack", 32'(ack), 32'd0);
    req_data[w*DW +: DW] = ~d;
    req_addr[w*AW +: AW] = ~a;
    if (HAS_GAP) begin
      cyc();
      check("g_enables", 32'({master_en, slave_en}), 32'd0);
      check("g_ack", 32'(ack), 32'd0);
    end
    cyc();
    check("s_slave_en", 32'(slave_en), 32'd1);
    check("s_master_en", 32'(master_en), 32'd0);
    check("s_ack", 32'(ack), 32'd0);
    cyc();
    check("d_ack", 32'(ack), 32'(exp_ack));
    check("d_slave_en", 32'(slave_en), 32'd0);
    check("d_busy", 32'(busy), 32'd1);
    check("d_lat_addr", 32'(lat_addr), 32'(a));
    check("d_lat_d", 32'(lat_d), 32'(d));
    req[w] = 1'b0;
    cyc();
    check("i_ack", 32'(ack), 32'd0);
    check("i_busy", 32'(busy), 32'd0);
    check("i_lat_d_hold", 32'(lat_d), 32'(d));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    prev_busy  = 1'b0;
    prev_lat_d = '0;
    rst        = 1'b1;
    req        = '0;
    req_addr   = '0;
    req_data   = '0;

    // Reset state
    cyc();
    cyc();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_lat_addr", 32'(lat_addr), 32'd0);
    check("rst_lat_d", 32'(lat_d), 32'd0);
    check("rst_enables", 32'({master_en, slave_en}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // No requests: stay idle
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_master_en", 32'(master_en), 32'd0);
    end

    // Single write from requester 1
    set_req(1, 3'd5, 8'hA5);
    expect_write(1, 3'd5, 8'hA5);

    // All four requesting from ptr=0: rotating grants 0,1,2,3
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_req(0, 3'd1, 8'h11);
    set_req(1, 3'd2, 8'h22);
    set_req(2, 3'd3, 8'h33);
    set_req(3, 3'd4, 8'h44);
    expect_write(0, 3'd1, 8'h11);
    expect_write(1, 3'd2, 8'h22);
    expect_write(2, 3'd3, 8'h33);
    expect_write(3, 3'd4, 8'h44);

    // Wrap: ptr back at 0 so 0 beats 3
    set_req(0, 3'd6, 8'h5A);
    set_req(3, 3'd7, 8'hC3);
    expect_write(0, 3'd6, 8'h5A);
    // ptr=1: late request from 2 beats waiting 3
    set_req(2, 3'd0, 8'h96);
    expect_write(2, 3'd0, 8'h96);
    expect_write(3, 3'd7, 8'hC3);

    // Reset during SLAVE aborts without ack and clears ptr
    set_req(0, 3'd2, 8'hE7);
    cyc();
    check("ab_master_en", 32'(master_en), 32'd1);
    if (HAS_GAP) begin
      cyc();
    end
    cyc();
    check("ab_slave_en", 32'(slave_en), 32'd1);
    rst = 1'b1;
    cyc();
    check("ab_rst_slave_en", 32'(slave_en), 32'd0);
    check("ab_rst_ack", 32'(ack), 32'd0);
    check("ab_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ab_no_ack", 32'(ack), 32'd0);
      check("ab_idle", 32'(busy), 32'd0);
    end
    // ptr must be 0 again: requester 0 beats 1
    set_req(0, 3'd3, 8'h0F);
    set_req(1, 3'd4, 8'hF0);
    expect_write(0, 3'd3, 8'h0F);
    expect_write(1, 3'd4, 8'hF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
